// File: rtl/intersection_phase_scheduler.sv
// Two-approach (NS/EW) signal sequencer: green -> yellow -> all-red -> other green,
// tick-timed phases, demand-driven green exit, latched crosswalk buttons and walk lamps.
module intersection_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 8,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       veh_ns,
  input  logic       veh_ew,
  input  logic       ped_ns,
  input  logic       ped_ew,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_NS = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_EW = 3'd5
  } state_e;

  // Lamp triplets are ordered {red, yellow, green}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_lat_ns_q, ped_lat_ns_d;
  logic             ped_lat_ew_q, ped_lat_ew_d;
  logic             walk_ns_q, walk_ns_d;
  logic             walk_ew_q, walk_ew_d;
  logic [2:0]       ns_lamp_q, ns_lamp_d;
  logic [2:0]       ew_lamp_q, ew_lamp_d;

  logic dem_ns, dem_ew;
  logic green_done;
  logic enter_ns_g, enter_ew_g;

  assign dem_ns = veh_ns | ped_lat_ns_q;
  assign dem_ew = veh_ew | ped_lat_ew_q;

  // Exit is allowed once the minimum is served; the GREEN_MAX term is the hard bound,
  // already implied by the >= comparison but kept explicit for parameter changes.
  assign green_done = (cnt_q >= GMIN_LAST) || (cnt_q >= GMAX_LAST);

  // NOTE: every signal assigned in this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NS_G:    if (tick && green_done && dem_ew) state_d = NS_Y;
      NS_Y:    if (tick && (cnt_q == YEL_LAST))  state_d = AR_NS;
      AR_NS:   if (tick && (cnt_q == AR_LAST))   state_d = EW_G;
      EW_G:    if (tick && green_done && dem_ns) state_d = EW_Y;
      EW_Y:    if (tick && (cnt_q == YEL_LAST))  state_d = AR_EW;
      AR_EW:   if (tick && (cnt_q == AR_LAST))   state_d = NS_G;
      default: state_d = AR_EW;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign enter_ns_g = (state_d == NS_G) && (state_q != NS_G);
  assign enter_ew_g = (state_d == EW_G) && (state_q != EW_G);

  // A press coinciding with green entry is served by that green's walk, so the latch
  // clears while the walk lamp still picks the press up.
  always_comb begin
    ped_lat_ns_d = enter_ns_g ? 1'b0 : (ped_lat_ns_q | ped_ns);
    ped_lat_ew_d = enter_ew_g ? 1'b0 : (ped_lat_ew_q | ped_ew);

    walk_ns_d = 1'b0;
    if (enter_ns_g) begin
      walk_ns_d = ped_lat_ns_q | ped_ns;
    end else if ((state_q == NS_G) && (state_d == NS_G)) begin
      walk_ns_d = walk_ns_q && !(tick && (cnt_q == WALK_LAST));
    end

    walk_ew_d = 1'b0;
    if (enter_ew_g) begin
      walk_ew_d = ped_lat_ew_q | ped_ew;
    end else if ((state_q == EW_G) && (state_d == EW_G)) begin
      walk_ew_d = walk_ew_q && !(tick && (cnt_q == WALK_LAST));
    end
  end

  // Lamps decode the next state so they switch on the same edge as the phase.
  always_comb begin
    ns_lamp_d = LAMP_R;
    ew_lamp_d = LAMP_R;
    unique case (state_d)
      NS_G:    ns_lamp_d = LAMP_G;
      NS_Y:    ns_lamp_d = LAMP_Y;
      EW_G:    ew_lamp_d = LAMP_G;
      EW_Y:    ew_lamp_d = LAMP_Y;
      default: begin
        ns_lamp_d = LAMP_R;
        ew_lamp_d = LAMP_R;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= AR_EW;
      cnt_q        <= '0;
      ped_lat_ns_q <= 1'b0;
      ped_lat_ew_q <= 1'b0;
      walk_ns_q    <= 1'b0;
      walk_ew_q    <= 1'b0;
      ns_lamp_q    <= LAMP_R;
      ew_lamp_q    <= LAMP_R;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ped_lat_ns_q <= ped_lat_ns_d;
      ped_lat_ew_q <= ped_lat_ew_d;
      walk_ns_q    <= walk_ns_d;
      walk_ew_q    <= walk_ew_d;
      ns_lamp_q    <= ns_lamp_d;
      ew_lamp_q    <= ew_lamp_d;
    end
  end

  assign {ns_red, ns_yellow, ns_green} = ns_lamp_q;
  assign {ew_red, ew_yellow, ew_green} = ew_lamp_q;
  assign walk_ns = walk_ns_q;
  assign walk_ew = walk_ew_q;
  assign phase   = state_q;

endmodule
